// File: rtl/icp_pkg.sv
// Shared memory-port definitions used by the icp cores and the memory arbiter.
package icp_pkg;

    typedef enum logic [1:0] {
        MEM_OP_NONE  = 2'd0,
        MEM_OP_READ  = 2'd1,
        MEM_OP_WRITE = 2'd2,
        MEM_OP_RSVD  = 2'd3
    } mem_op_t;

    localparam int MEM_ADDR_W = 13;
    localparam int MEM_DATA_W = 64;

    // Only READ and WRITE claim the memory; the reserved code is treated as idle.
    function automatic logic is_mem_req(input logic [1:0] op);
        return (op == MEM_OP_READ) || (op == MEM_OP_WRITE);
    endfunction

endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate requests to start at the pointer,
// take the lowest set bit, then rotate the index back into port numbering.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [NUM_REQ-1:0] rot;
    int                 off;

    // Explicit wrap keeps non-power-of-two port counts inside 0..NUM_REQ-1.
    function automatic logic [IDX_W-1:0] wrap(input int s);
        int t;
        t = (s >= NUM_REQ) ? s - NUM_REQ : s;
        return IDX_W'(t);
    endfunction

    always_comb begin
        rot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rot[i] = req[wrap(int'(ptr) + i)];
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        any = 1'b0;
        off = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                any = 1'b1;
                off = i;
            end
        end
    end

    always_comb begin
        idx = wrap(int'(ptr) + off);
        gnt = any ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-ported word memory with tagged fixed-latency read return.
// Define ARB_STATS_EN to add per-port saturating grant counters on o_gnt_cnt.
module mem_rr_arbiter
    import icp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W,
    parameter int RD_LAT  = 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0][1:0]        i_req_op,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] i_req_wdata,
    output logic [NUM_REQ-1:0]             o_req_gnt,
    output logic [NUM_REQ-1:0]             o_req_rvalid,
    output logic [DATA_W-1:0]              o_req_rdata,
    output mem_op_t                        o_mem_op,
    output logic [ADDR_W-1:0]              o_mem_addr,
    output logic [DATA_W-1:0]              o_mem_wdata,
    input  logic [DATA_W-1:0]              i_mem_rdata,
`ifdef ARB_STATS_EN
    output logic [NUM_REQ-1:0][31:0]       o_gnt_cnt,
`endif
    output logic                           o_busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

    logic [NUM_REQ-1:0] req_vec;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [IDX_W-1:0]   ptr_q;
    mem_op_t            gnt_op;
    logic               grant;
    tag_t               tag_q [RD_LAT+1];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_vec[i] = is_mem_req(i_req_op[i]);
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req (req_vec),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign grant     = pick_any && !i_rst;
    assign o_req_gnt = grant ? pick_gnt : '0;
    assign gnt_op    = mem_op_t'(i_req_op[pick_idx]);

    // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q       <= '0;
            o_mem_op    <= MEM_OP_NONE;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else if (grant) begin
            ptr_q       <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
            o_mem_op    <= gnt_op;
            o_mem_addr  <= i_req_addr[pick_idx];
            o_mem_wdata <= i_req_wdata[pick_idx];
        end else begin
            o_mem_op    <= MEM_OP_NONE;
        end
    end

    // Tag stage RD_LAT lines up with i_mem_rdata for the read that entered RD_LAT+1 edges earlier.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the tag pipe is a handful of flops, not a RAM, so it is reset; clearing valid discards in-flight reads.
            for (int i = 0; i <= RD_LAT; i++) begin
                tag_q[i] <= '0;
            end
            o_req_rvalid <= '0;
            o_req_rdata  <= '0;
        end else begin
            tag_q[0].valid <= grant && (gnt_op == MEM_OP_READ);
            tag_q[0].idx   <= pick_idx;
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            o_req_rvalid <= tag_q[RD_LAT].valid ? (NUM_REQ'(1) << tag_q[RD_LAT].idx) : '0;
            if (tag_q[RD_LAT].valid) begin
                o_req_rdata <= i_mem_rdata;
            end
        end
    end

    always_comb begin
        o_busy = 1'b0;
        for (int i = 0; i <= RD_LAT; i++) begin
            o_busy = o_busy | tag_q[i].valid;
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_gnt_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (o_req_gnt[i] && (o_gnt_cnt[i] != 32'hFFFF_FFFF)) begin
                    o_gnt_cnt[i] <= o_gnt_cnt[i] + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench: two arbiters (RD_LAT 1 and 3) share stimulus and are compared
// against a queue-based reference model of round-robin grants and read returns.
module tb_mem_rr_arbiter;
    import icp_pkg::*;

    localparam int N  = 4;
    localparam int AW = 13;
    localparam int DW = 64;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic                     i_rst;
    logic [N-1:0][1:0]        req_op;
    logic [N-1:0][AW-1:0]     req_addr;
    logic [N-1:0][DW-1:0]     req_wdata;

    logic [N-1:0]  gnt1, rv1, gnt3, rv3;
    logic [DW-1:0] rd1, rd3, mwd1, mwd3, mrd1, mrd3;
    logic [1:0]    mop1, mop3;
    logic [AW-1:0] maddr1, maddr3;
    logic          busy1, busy3;
`ifdef ARB_STATS_EN
    logic [N-1:0][31:0] cnt1, cnt3;
`endif

    mem_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_req_op(req_op), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .o_req_gnt(gnt1), .o_req_rvalid(rv1), .o_req_rdata(rd1),
        .o_mem_op(mop1), .o_mem_addr(maddr1), .o_mem_wdata(mwd1), .i_mem_rdata(mrd1),
`ifdef ARB_STATS_EN
        .o_gnt_cnt(cnt1),
`endif
        .o_busy(busy1));

    mem_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_dut3 (
        .i_clk(i_clk), .i_rst(i_rst), .i_req_op(req_op), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .o_req_gnt(gnt3), .o_req_rvalid(rv3), .o_req_rdata(rd3),
        .o_mem_op(mop3), .o_mem_addr(maddr3), .o_mem_wdata(mwd3), .i_mem_rdata(mrd3),
`ifdef ARB_STATS_EN
        .o_gnt_cnt(cnt3),
`endif
        .o_busy(busy3));

    // Behavioural single-port memories; data is junk except RD_LAT cycles after a READ.
    localparam logic [DW-1:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;
    logic [DW-1:0] mem1 [2**AW] = '{default: '0};
    logic [DW-1:0] mem3 [2**AW] = '{default: '0};
    logic [DW-1:0] p1;
    logic [DW-1:0] p3 [3];

    always @(posedge i_clk) begin
        if (mop1 == 2'd2) mem1[maddr1] <= mwd1;
        p1 <= (mop1 == 2'd1) ? mem1[maddr1] : JUNK;
        if (mop3 == 2'd2) mem3[maddr3] <= mwd3;
        p3[0] <= (mop3 == 2'd1) ? mem3[maddr3] : JUNK;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mrd1 = p1;
    assign mrd3 = p3[2];

    // Reference model state
    typedef struct { int port; logic [DW-1:0] data; int due; } exp_t;
    exp_t          q1[$], q3[$];
    logic [DW-1:0] ref_mem [2**AW] = '{default: '0};
    int            ptr_m = 0;
    int            cnt_m [N] = '{default: 0};
    logic [1:0]    exp_op = 2'd0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_wd = '0;
    bit            known = 1'b0;
    int            cyc = 0;
    int            n_assert = 0;
    int            n_fail = 0;
    logic [N-1:0]  last_gnt, last_rv1, last_rv3;
    logic [DW-1:0] last_rd1;

    // One clock of stimulus: compare the sampled outputs with the model, then advance the model.
    task automatic run_cycle();
        int            k;
        logic [N-1:0]  eg, erv1, erv3;
        logic [DW-1:0] erd1, erd3;
        @(negedge i_clk);
        k = -1;
        if (!i_rst) begin
            for (int i = 0; i < N; i++) begin
                int p;
                p = (ptr_m + i) % N;
                if (k < 0 && (req_op[p] == 2'd1 || req_op[p] == 2'd2)) k = p;
            end
        end
        eg = (k >= 0) ? (N'(1) << k) : '0;
        n_assert++; if (gnt1 !== eg) begin n_fail++; $display("FAIL gnt1 cyc %0d: got %b want %b", cyc, gnt1, eg); end
        n_assert++; if (gnt3 !== eg) begin n_fail++; $display("FAIL gnt3 cyc %0d: got %b want %b", cyc, gnt3, eg); end
        last_gnt = gnt1;
        last_rv1 = rv1;
        last_rv3 = rv3;
        last_rd1 = rd1;
        if (known) begin
            n_assert++; if (mop1 !== exp_op) begin n_fail++; $display("FAIL mem_op1 cyc %0d: got %0d want %0d", cyc, mop1, exp_op); end
            n_assert++; if (mop3 !== exp_op) begin n_fail++; $display("FAIL mem_op3 cyc %0d: got %0d want %0d", cyc, mop3, exp_op); end
            if (exp_op != 2'd0) begin
                n_assert++; if (maddr1 !== exp_addr) begin n_fail++; $display("FAIL mem_addr1 cyc %0d: got %0h want %0h", cyc, maddr1, exp_addr); end
                n_assert++; if (maddr3 !== exp_addr) begin n_fail++; $display("FAIL mem_addr3 cyc %0d: got %0h want %0h", cyc, maddr3, exp_addr); end
            end
            if (exp_op == 2'd2) begin
                n_assert++; if (mwd1 !== exp_wd) begin n_fail++; $display("FAIL mem_wdata1 cyc %0d: got %0h want %0h", cyc, mwd1, exp_wd); end
            end
            erv1 = '0; erd1 = '0; erv3 = '0; erd3 = '0;
            if (q1.size() > 0 && q1[0].due == cyc) begin
                erv1 = N'(1) << q1[0].port; erd1 = q1[0].data; void'(q1.pop_front());
            end
            if (q3.size() > 0 && q3[0].due == cyc) begin
                erv3 = N'(1) << q3[0].port; erd3 = q3[0].data; void'(q3.pop_front());
            end
            n_assert++; if (rv1 !== erv1) begin n_fail++; $display("FAIL rvalid1 cyc %0d: got %b want %b", cyc, rv1, erv1); end
            n_assert++; if (rv3 !== erv3) begin n_fail++; $display("FAIL rvalid3 cyc %0d: got %b want %b", cyc, rv3, erv3); end
            if (erv1 != '0) begin
                n_assert++; if (rd1 !== erd1) begin n_fail++; $display("FAIL rdata1 cyc %0d: got %0h want %0h", cyc, rd1, erd1); end
            end
            if (erv3 != '0) begin
                n_assert++; if (rd3 !== erd3) begin n_fail++; $display("FAIL rdata3 cyc %0d: got %0h want %0h", cyc, rd3, erd3); end
            end
            n_assert++; if (busy1 !== (q1.size() != 0)) begin n_fail++; $display("FAIL busy1 cyc %0d: got %b want %b", cyc, busy1, q1.size() != 0); end
            n_assert++; if (busy3 !== (q3.size() != 0)) begin n_fail++; $display("FAIL busy3 cyc %0d: got %b want %b", cyc, busy3, q3.size() != 0); end
        end
        exp_op = 2'd0;
        if (k >= 0) begin
            exp_op   = req_op[k];
            exp_addr = req_addr[k];
            exp_wd   = req_wdata[k];
            ptr_m    = (k + 1) % N;
            cnt_m[k]++;
            if (req_op[k] == 2'd2) ref_mem[req_addr[k]] = req_wdata[k];
            else begin
                q1.push_back('{port: k, data: ref_mem[req_addr[k]], due: cyc + 3});
                q3.push_back('{port: k, data: ref_mem[req_addr[k]], due: cyc + 5});
            end
        end
        if (i_rst) begin
            q1.delete(); q3.delete();
            ptr_m = 0; exp_op = 2'd0; exp_addr = '0; exp_wd = '0;
            for (int i = 0; i < N; i++) cnt_m[i] = 0;
            known = 1'b1;
        end
        @(posedge i_clk);
        cyc++;
        #1;
    endtask

    task automatic all_none();
        for (int i = 0; i < N; i++) req_op[i] = 2'd0;
    endtask

    task automatic pulse_reset();
        i_rst = 1'b1;
        run_cycle();
        i_rst = 1'b0;
    endtask

    // Wait for rvalid on port p of the RD_LAT=1 arbiter; returns the cycle it appeared in, or -1.
    task automatic wait_rv1(input int p, output int at);
        at = -1;
        for (int i = 0; i < 10 && at < 0; i++) begin
            run_cycle();
            if (last_rv1[p]) at = cyc - 1;
        end
        n_assert++; if (at < 0) begin n_fail++; $display("FAIL rvalid_timeout port %0d: got none want one within 10 cycles", p); end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_op[i] = 2'd1; req_addr[i] = AW'(i); req_wdata[i] = '0;
        end
        run_cycle();
        run_cycle();
        i_rst = 1'b0;
        all_none();
        n_assert++; if (mop1 !== 2'd0 || mop3 !== 2'd0) begin n_fail++; $display("FAIL reset_mem_op: got %0d/%0d want 0", mop1, mop3); end
        n_assert++; if (maddr1 !== '0 || mwd1 !== '0) begin n_fail++; $display("FAIL reset_mem_addr_wdata: got %0h/%0h want 0", maddr1, mwd1); end
        n_assert++; if (rd1 !== '0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_rdata_busy: got %0h/%b want 0/0", rd1, busy1); end
        for (int i = 0; i < 10; i++) run_cycle();
    endtask

    task automatic test_single_read();
        int t, at;
        req_op[2] = 2'd2; req_addr[2] = 13'h005; req_wdata[2] = 64'h1234;
        run_cycle();
        n_assert++; if (last_gnt !== 4'b0100) begin n_fail++; $display("FAIL single_write_gnt: got %b want 0100", last_gnt); end
        req_op[2] = 2'd1;
        run_cycle();
        t = cyc - 1;
        n_assert++; if (last_gnt !== 4'b0100) begin n_fail++; $display("FAIL single_read_gnt: got %b want 0100", last_gnt); end
        req_op[2] = 2'd0;
        n_assert++; if (mop1 !== 2'd1 || maddr1 !== 13'h005) begin n_fail++; $display("FAIL single_read_issue: got op %0d addr %0h want 1 005", mop1, maddr1); end
        wait_rv1(2, at);
        n_assert++; if (at != t + 3) begin n_fail++; $display("FAIL single_read_latency: got cycle %0d want %0d", at, t + 3); end
        n_assert++; if (last_rd1 !== 64'h1234) begin n_fail++; $display("FAIL single_read_data: got %0h want 1234", last_rd1); end
        for (int i = 0; i < 6; i++) run_cycle();
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 400; c++) begin
            i_rst = ($urandom_range(0, 149) == 0);
            run_cycle();
            for (int p = 0; p < N; p++) begin
                if (last_gnt[p] || !(req_op[p] == 2'd1 || req_op[p] == 2'd2)) begin
                    r = $urandom_range(0, 9);
                    req_op[p]    = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
                    req_addr[p]  = AW'($urandom_range(0, 15));
                    req_wdata[p] = {$urandom, $urandom};
                end
            end
        end
        i_rst = 1'b0;
        all_none();
        for (int i = 0; i < 8; i++) run_cycle();
    endtask

    task automatic test_all_read();
        int n [N] = '{default: 0};
        pulse_reset();
        for (int p = 0; p < N; p++) begin
            req_op[p] = 2'd1; req_addr[p] = AW'(p * 4);
        end
        for (int i = 0; i < 12; i++) begin
            run_cycle();
            n_assert++; if (last_gnt !== (N'(1) << (i % N))) begin n_fail++; $display("FAIL all_read_order %0d: got %b want %b", i, last_gnt, N'(1) << (i % N)); end
            for (int p = 0; p < N; p++) begin
                if (last_gnt[p]) begin
                    n[p]++;
                    req_addr[p] = AW'(p * 4 + n[p] % 4);
                end
            end
        end
        all_none();
        for (int i = 0; i < 8; i++) run_cycle();
    endtask

    task automatic test_write_order();
        int at;
        pulse_reset();
        req_op[1] = 2'd1; req_addr[1] = 13'h003;
        run_cycle();
        req_op[1] = 2'd2; req_addr[1] = 13'h010; req_wdata[1] = 64'hAA;
        req_op[3] = 2'd2; req_addr[3] = 13'h010; req_wdata[3] = 64'hBB;
        run_cycle();
        n_assert++; if (last_gnt !== 4'b1000) begin n_fail++; $display("FAIL write_first_gnt: got %b want 1000", last_gnt); end
        req_op[3] = 2'd0;
        run_cycle();
        n_assert++; if (last_gnt !== 4'b0010) begin n_fail++; $display("FAIL write_second_gnt: got %b want 0010", last_gnt); end
        req_op[1] = 2'd0;
        for (int i = 0; i < 3; i++) run_cycle();
        n_assert++; if (mem1[16] !== 64'hAA || mem3[16] !== 64'hAA) begin n_fail++; $display("FAIL write_final_mem: got %0h/%0h want aa", mem1[16], mem3[16]); end
        req_op[0] = 2'd1; req_addr[0] = 13'h010;
        run_cycle();
        req_op[0] = 2'd0;
        wait_rv1(0, at);
        n_assert++; if (last_rd1 !== 64'hAA) begin n_fail++; $display("FAIL write_readback: got %0h want aa", last_rd1); end
        for (int i = 0; i < 6; i++) run_cycle();
    endtask

    task automatic test_reserved_op();
        req_op[0] = 2'd3; req_addr[0] = 13'h001;
        req_op[1] = 2'd1; req_addr[1] = 13'h002;
        run_cycle();
        n_assert++; if (last_gnt !== 4'b0010) begin n_fail++; $display("FAIL rsvd_gnt: got %b want 0010", last_gnt); end
        req_op[1] = 2'd0;
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            n_assert++; if (last_gnt !== 4'b0000 || mop1 === 2'd3) begin n_fail++; $display("FAIL rsvd_idle: got gnt %b op %0d want 0000 and op!=3", last_gnt, mop1); end
        end
        all_none();
        for (int i = 0; i < 6; i++) run_cycle();
    endtask

    task automatic test_reset_mid_read();
        int seen;
        pulse_reset();
        seen = 0;
        for (int p = 0; p < 3; p++) begin
            req_op[p] = 2'd1; req_addr[p] = AW'(p + 8);
        end
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            n_assert++; if (last_gnt !== (N'(1) << i)) begin n_fail++; $display("FAIL mid_gnt %0d: got %b want %b", i, last_gnt, N'(1) << i); end
            req_op[i] = 2'd0;
            if (last_rv3 != '0) seen++;
        end
        i_rst = 1'b1;
        run_cycle();
        if (last_rv3 != '0) seen++;
        i_rst = 1'b0;
        n_assert++; if (busy1 !== 1'b0 || busy3 !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b/%b want 0/0", busy1, busy3); end
        for (int p = 0; p < N; p++) req_op[p] = 2'd1;
        run_cycle();
        n_assert++; if (last_gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr: got %b want 0001", last_gnt); end
        all_none();
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            if (last_rv3 != '0) seen++;
        end
        n_assert++; if (seen != 0) begin n_fail++; $display("FAIL mid_stray_rvalid: got %0d want 0", seen); end
        for (int i = 0; i < 8; i++) run_cycle();
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        for (int p = 0; p < N; p++) begin
            n_assert++; if (cnt1[p] !== 32'(cnt_m[p]) || cnt3[p] !== 32'(cnt_m[p])) begin n_fail++; $display("FAIL gnt_cnt port %0d: got %0d/%0d want %0d", p, cnt1[p], cnt3[p], cnt_m[p]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_random();
        test_all_read();
        test_write_order();
        test_reserved_op();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
